bram_sdp_be: RTL and testbench

- Parametrised simple-dual-port block RAM: one write port, one read port, both on a single clock.
- Generalises the 32-bit single-port word/half/byte RAM:
  - arbitrary data width;
  - per-byte write-enable mask instead of an encoded subaddress;
  - independent read address;
  - read-valid tracking;
  - selectable read-during-write behaviour;
  - optional output pipeline register.
- Used for instruction/data memories and peripheral buffers where fetch and store must proceed in the same cycle.

---
 rtl/bram_sdp_be.sv | 158 +++++++++++++++
 tb/tb_bram_sdp_be.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_sdp_be.sv
`default_nettype none
// ============================================================================
//  Module   : bram_sdp_be
//  Purpose  : Simple-dual-port block RAM with per-byte write enables, an
//             independent read port, read-valid tracking, selectable
//             read-during-write behaviour and an optional output register.
//  Revision : 1.0 - initial release
// ============================================================================
module bram_sdp_be #(
    parameter int    DATA_WIDTH = 32,
    parameter int    DEPTH      = 512,
    parameter int    OUT_REG    = 0,
    parameter int    RDW_MODE   = 0,
    parameter string INIT_FILE  = "",
    localparam int   ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_wr_en,
    input  logic [ADDR_WIDTH-1:0]   i_wr_addr,
    input  logic [DATA_WIDTH-1:0]   i_wr_data,
    input  logic [DATA_WIDTH/8-1:0] i_wr_be,
    input  logic                    i_rd_en,
    input  logic [ADDR_WIDTH-1:0]   i_rd_addr,
    output logic [DATA_WIDTH-1:0]   o_rd_data,
    output logic                    o_rd_valid
);

    localparam int c_NUM_BYTES = DATA_WIDTH / 8;

    // Parameter sanity checks at elaboration time.
    generate
        if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_width
            $error("bram_sdp_be: DATA_WIDTH must be a non-zero multiple of 8");
        end
        if (DEPTH < 2) begin : g_bad_depth
            $error("bram_sdp_be: DEPTH must be at least 2");
        end
    endgenerate

    // Storage array; no reset so it maps onto a single block RAM.
    logic [DATA_WIDTH-1:0]  r_mem [0:DEPTH-1];

    logic                   w_wr_in_range;
    logic                   w_rd_in_range;
    logic                   w_wr_fire;
    logic                   w_rd_fire;
    logic [c_NUM_BYTES-1:0] w_byp_mask;

    logic [DATA_WIDTH-1:0]  r_ram_q;
    logic                   r_rd1_valid;
    logic                   r_rd1_in_range;
    logic [c_NUM_BYTES-1:0] r_byp_mask;
    logic [DATA_WIDTH-1:0]  r_byp_data;
    logic [DATA_WIDTH-1:0]  w_rd1_data;

    // Address range qualification: only a non-power-of-two depth has holes.
    generate
        if (DEPTH == (1 << ADDR_WIDTH)) begin : g_full_range
            assign w_wr_in_range = 1'b1;
            assign w_rd_in_range = 1'b1;
        end else begin : g_partial_range
            localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
            assign w_wr_in_range = (i_wr_addr <= c_LAST_ADDR);
            assign w_rd_in_range = (i_rd_addr <= c_LAST_ADDR);
        end
    endgenerate

    // Requests are ignored while reset is held.
    assign w_wr_fire = i_wr_en & w_wr_in_range & ~i_rst;
    assign w_rd_fire = i_rd_en & ~i_rst;

    // Collision bypass mask: bytes of the read word that must come from the
    // concurrent write rather than from the (read-first) RAM output.
    always_comb begin
        w_byp_mask = '0;
        if ((RDW_MODE != 0) && w_wr_fire && (i_wr_addr == i_rd_addr)) begin
            w_byp_mask = i_wr_be;
        end
    end

    // Power-up contents: all zeros.
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] = '0;
        end
    end

    // RAM core: byte-masked write port and read-first registered read port.
    always @(posedge i_clk) begin
        if (w_wr_fire) begin
            for (int k = 0; k < c_NUM_BYTES; k++) begin
                if (i_wr_be[k]) begin
                    r_mem[i_wr_addr][8*k +: 8] <= i_wr_data[8*k +: 8];
                end
            end
        end
        if (w_rd_fire) begin
            r_ram_q <= r_mem[i_rd_addr];
        end
    end

    // Stage-1 side information captured alongside each read.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd1_valid    <= 1'b0;
            r_rd1_in_range <= 1'b0;
            r_byp_mask     <= '0;
            r_byp_data     <= '0;
        end else begin
            r_rd1_valid <= i_rd_en;
            if (i_rd_en) begin
                r_rd1_in_range <= w_rd_in_range;
                r_byp_mask     <= w_byp_mask;
                r_byp_data     <= i_wr_data;
            end
        end
    end

    // Stage-1 data: zero for out-of-range (and after reset), otherwise the RAM
    // word with collided bytes replaced by the registered write data.
    always_comb begin
        w_rd1_data = '0;
        if (r_rd1_in_range) begin
            for (int k = 0; k < c_NUM_BYTES; k++) begin
                w_rd1_data[8*k +: 8] = r_byp_mask[k] ? r_byp_data[8*k +: 8]
                                                     : r_ram_q[8*k +: 8];
            end
        end
    end

    // Optional output register; data and valid advance together.
    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] r_rd2_data;
            logic                  r_rd2_valid;

            // Second pipeline stage copies stage 1 every cycle.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_rd2_data  <= '0;
                    r_rd2_valid <= 1'b0;
                end else begin
                    r_rd2_data  <= w_rd1_data;
                    r_rd2_valid <= r_rd1_valid;
                end
            end

            assign o_rd_data  = r_rd2_data;
            assign o_rd_valid = r_rd2_valid;
        end else begin : g_no_out_reg
            assign o_rd_data  = w_rd1_data;
            assign o_rd_valid = r_rd1_valid;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_bram_sdp_be.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bram_sdp_be
//  Purpose  : Self-checking bench for bram_sdp_be. Three configurations run
//             side by side against a per-configuration reference memory.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bram_sdp_be;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    // Shared stimulus for the two 32-bit instances (A: 512 deep, latency 1,
    // old-data collisions; B: 500 deep, latency 2, new-data collisions).
    logic        ab_wr_en;
    logic [8:0]  ab_wr_addr;
    logic [31:0] ab_wr_data;
    logic [3:0]  ab_wr_be;
    logic        ab_rd_en;
    logic [8:0]  ab_rd_addr;
    logic [31:0] a_rd_data, b_rd_data;
    logic        a_rd_valid, b_rd_valid;

    // 64-bit instance C: 600 deep, latency 1, new-data collisions.
    logic        c_wr_en;
    logic [9:0]  c_wr_addr;
    logic [63:0] c_wr_data;
    logic [7:0]  c_wr_be;
    logic        c_rd_en;
    logic [9:0]  c_rd_addr;
    logic [63:0] c_rd_data;
    logic        c_rd_valid;

    bram_sdp_be #(.DATA_WIDTH(32), .DEPTH(512), .OUT_REG(0), .RDW_MODE(0)) u_dut_a (
        .i_clk(clk), .i_rst(rst),
        .i_wr_en(ab_wr_en), .i_wr_addr(ab_wr_addr), .i_wr_data(ab_wr_data), .i_wr_be(ab_wr_be),
        .i_rd_en(ab_rd_en), .i_rd_addr(ab_rd_addr),
        .o_rd_data(a_rd_data), .o_rd_valid(a_rd_valid)
    );

    bram_sdp_be #(.DATA_WIDTH(32), .DEPTH(500), .OUT_REG(1), .RDW_MODE(1)) u_dut_b (
        .i_clk(clk), .i_rst(rst),
        .i_wr_en(ab_wr_en), .i_wr_addr(ab_wr_addr), .i_wr_data(ab_wr_data), .i_wr_be(ab_wr_be),
        .i_rd_en(ab_rd_en), .i_rd_addr(ab_rd_addr),
        .o_rd_data(b_rd_data), .o_rd_valid(b_rd_valid)
    );

    bram_sdp_be #(.DATA_WIDTH(64), .DEPTH(600), .OUT_REG(0), .RDW_MODE(1)) u_dut_c (
        .i_clk(clk), .i_rst(rst),
        .i_wr_en(c_wr_en), .i_wr_addr(c_wr_addr), .i_wr_data(c_wr_data), .i_wr_be(c_wr_be),
        .i_rd_en(c_rd_en), .i_rd_addr(c_rd_addr),
        .o_rd_data(c_rd_data), .o_rd_valid(c_rd_valid)
    );

    // Reference model configuration and state, one slot per instance.
    int          cfg_depth [3] = '{512, 500, 600};
    int          cfg_lat   [3] = '{1, 2, 1};
    int          cfg_rdw   [3] = '{0, 1, 1};
    int          cfg_bytes [3] = '{4, 4, 8};

    logic [63:0] mdl_mem   [3][1024];
    bit          iss_now   [3];
    bit          iss_prev  [3];
    logic [63:0] res_now   [3];
    logic [63:0] res_prev  [3];
    logic [63:0] hold      [3];
    bit          exp_valid [3];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, expv);
        end
    endtask

    function automatic logic [63:0] merge(input logic [63:0] old_w, input logic [63:0] new_w,
                                          input logic [7:0] be, input int nbytes);
        logic [63:0] r;
        r = old_w;
        for (int k = 0; k < nbytes; k++) begin
            if (be[k]) r[8*k +: 8] = new_w[8*k +: 8];
        end
        return r;
    endfunction

    // Apply one clock edge's worth of requests to model d and work out what
    // the outputs should show right after that edge.
    task automatic mdl_edge(input int d, input bit r, input bit we, input int wa,
                            input logic [63:0] wd, input logic [7:0] be,
                            input bit re, input int ra);
        logic [63:0] word;
        bit          dv;
        logic [63:0] dd;
        iss_prev[d] = iss_now[d];
        res_prev[d] = res_now[d];
        iss_now[d]  = re && !r;
        if (ra < cfg_depth[d]) begin
            word = mdl_mem[d][ra];
            if (cfg_rdw[d] == 1 && we && !r && wa == ra) word = merge(word, wd, be, cfg_bytes[d]);
        end else begin
            word = 64'h0;
        end
        res_now[d] = word;
        if (we && !r && wa < cfg_depth[d]) mdl_mem[d][wa] = merge(mdl_mem[d][wa], wd, be, cfg_bytes[d]);
        if (cfg_lat[d] == 1) begin
            dv = iss_now[d];
            dd = res_now[d];
        end else begin
            dv = iss_prev[d] && !r;
            dd = res_prev[d];
        end
        if (r) hold[d] = 64'h0;
        else if (dv) hold[d] = dd;
        exp_valid[d] = dv;
    endtask

    // One clock cycle: update models, advance, compare every output.
    task automatic cyc();
        mdl_edge(0, rst, ab_wr_en, int'(ab_wr_addr), {32'h0, ab_wr_data}, {4'h0, ab_wr_be}, ab_rd_en, int'(ab_rd_addr));
        mdl_edge(1, rst, ab_wr_en, int'(ab_wr_addr), {32'h0, ab_wr_data}, {4'h0, ab_wr_be}, ab_rd_en, int'(ab_rd_addr));
        mdl_edge(2, rst, c_wr_en, int'(c_wr_addr), c_wr_data, c_wr_be, c_rd_en, int'(c_rd_addr));
        @(posedge clk);
        #1;
        check("a_valid", a_rd_valid, exp_valid[0]);
        check("a_data",  a_rd_data,  hold[0]);
        check("b_valid", b_rd_valid, exp_valid[1]);
        check("b_data",  b_rd_data,  hold[1]);
        check("c_valid", c_rd_valid, exp_valid[2]);
        check("c_data",  c_rd_data,  hold[2]);
    endtask

    task automatic idle_all();
        rst = 1'b0;
        ab_wr_en = 1'b0; ab_rd_en = 1'b0;
        c_wr_en  = 1'b0; c_rd_en  = 1'b0;
    endtask

    task automatic ab_wr(input logic [8:0] a, input logic [31:0] d, input logic [3:0] be);
        ab_wr_en = 1'b1; ab_wr_addr = a; ab_wr_data = d; ab_wr_be = be;
    endtask

    task automatic ab_rd(input logic [8:0] a);
        ab_rd_en = 1'b1; ab_rd_addr = a;
    endtask

    task automatic c_wr(input logic [9:0] a, input logic [63:0] d, input logic [7:0] be);
        c_wr_en = 1'b1; c_wr_addr = a; c_wr_data = d; c_wr_be = be;
    endtask

    task automatic c_rd(input logic [9:0] a);
        c_rd_en = 1'b1; c_rd_addr = a;
    endtask

    function automatic logic [8:0] pick_ab();
        if ($urandom_range(0, 3) == 0) return 9'($urandom_range(496, 511));
        return 9'($urandom_range(0, 7));
    endfunction

    function automatic logic [9:0] pick_c();
        int s;
        s = $urandom_range(0, 3);
        if (s == 0) return 10'($urandom_range(596, 603));
        if (s == 1) return 10'($urandom_range(1016, 1023));
        return 10'($urandom_range(0, 7));
    endfunction

    initial begin
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 1024; i++) mdl_mem[d][i] = 64'h0;
            iss_now[d] = 1'b0; iss_prev[d] = 1'b0;
            res_now[d] = 64'h0; res_prev[d] = 64'h0;
            hold[d] = 64'h0; exp_valid[d] = 1'b0;
        end
        ab_wr_addr = '0; ab_wr_data = '0; ab_wr_be = '0; ab_rd_addr = '0;
        c_wr_addr  = '0; c_wr_data  = '0; c_wr_be  = '0; c_rd_addr  = '0;
        idle_all();

        // Reset, then a read of address 0 on the first edge after release.
        rst = 1'b1; cyc();
        check("rst_a_valid", a_rd_valid, 1'b0);
        rst = 1'b1; cyc();
        idle_all(); ab_rd(9'd0); cyc();
        check("rst_rd_a_valid", a_rd_valid, 1'b1);
        check("rst_rd_a_data",  a_rd_data,  32'h0);

        // Byte-enable merge.
        idle_all(); ab_wr(9'd5, 32'hAABBCCDD, 4'b1111); cyc();
        idle_all(); ab_wr(9'd5, 32'h11223344, 4'b0101); cyc();
        idle_all(); ab_rd(9'd5); cyc();
        check("be_merge_a", a_rd_data, 32'hAA22CC44);
        idle_all(); cyc();
        check("be_merge_b", b_rd_data, 32'hAA22CC44);

        // Same-address read during write.
        idle_all(); ab_wr(9'd7, 32'h01020304, 4'b1111); cyc();
        idle_all(); ab_wr(9'd7, 32'hF0F0F0F0, 4'b0011); ab_rd(9'd7); cyc();
        check("coll_old_a", a_rd_data, 32'h01020304);
        idle_all(); ab_rd(9'd7); cyc();
        check("coll_new_b", b_rd_data, 32'h0102F0F0);
        check("after_coll_a", a_rd_data, 32'h0102F0F0);
        idle_all(); cyc();
        check("after_coll_b", b_rd_data, 32'h0102F0F0);

        // Back-to-back stream through the two-stage instance.
        for (int i = 0; i < 4; i++) begin
            idle_all(); ab_wr(9'(i), 32'(i), 4'b1111); cyc();
        end
        for (int i = 0; i < 4; i++) begin
            idle_all(); ab_rd(9'(i)); cyc();
        end
        idle_all(); cyc();
        check("stream_last_b", b_rd_data, 32'd3);
        idle_all(); cyc();
        check("stream_hold_b",  b_rd_data,  32'd3);
        check("stream_idle_bv", b_rd_valid, 1'b0);

        // Reset while a read is in flight.
        idle_all(); ab_wr(9'd9, 32'h5A5AA5A5, 4'b1111); cyc();
        idle_all(); ab_rd(9'd9); cyc();
        idle_all(); rst = 1'b1; cyc();
        check("midrst_b_valid", b_rd_valid, 1'b0);
        check("midrst_b_data",  b_rd_data,  32'h0);
        idle_all(); cyc();
        check("postrst_b_valid", b_rd_valid, 1'b0);
        idle_all(); ab_rd(9'd9); cyc();
        idle_all(); cyc();
        check("postrst_b_data", b_rd_data, 32'h5A5AA5A5);

        // Out-of-range access on the 500-deep instance.
        idle_all(); ab_wr(9'd505, 32'hDEADBEEF, 4'b1111); cyc();
        idle_all(); ab_rd(9'd505); cyc();
        idle_all(); cyc();
        check("oor_b_data",  b_rd_data,  32'h0);
        check("oor_b_valid", b_rd_valid, 1'b1);

        // Wide word, top-byte enable, and out-of-range on the 64-bit instance.
        idle_all(); c_wr(10'd599, 64'h0123456789ABCDEF, 8'hFF); cyc();
        idle_all(); c_wr(10'd599, 64'hEE00000000000000, 8'h80); cyc();
        idle_all(); c_rd(10'd599); cyc();
        check("wide_be_c", c_rd_data, 64'hEE23456789ABCDEF);
        idle_all(); c_wr(10'd700, 64'hFFFFFFFFFFFFFFFF, 8'hFF); cyc();
        idle_all(); c_rd(10'd700); cyc();
        check("oor_c_data",  c_rd_data,  64'h0);
        check("oor_c_valid", c_rd_valid, 1'b1);

        // Randomised traffic with collisions, out-of-range and sporadic resets.
        for (int n = 0; n < 400; n++) begin
            idle_all();
            rst        = ($urandom_range(0, 49) == 0);
            ab_wr_en   = 1'($urandom_range(0, 1));
            ab_wr_addr = pick_ab();
            ab_wr_data = $urandom;
            ab_wr_be   = 4'($urandom);
            ab_rd_en   = 1'($urandom_range(0, 1));
            ab_rd_addr = pick_ab();
            c_wr_en    = 1'($urandom_range(0, 1));
            c_wr_addr  = pick_c();
            c_wr_data  = {$urandom, $urandom};
            c_wr_be    = 8'($urandom);
            c_rd_en    = 1'($urandom_range(0, 1));
            c_rd_addr  = ($urandom_range(0, 2) == 0) ? c_wr_addr : pick_c();
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
